// File: rtl/led_panel_receiver.sv
// led_panel_receiver: oversamples HUB75-style panel pins and presents each latched row as a ready/valid record
module led_panel_receiver #(
  parameter int NUM_ROWS = 32,
  parameter int NUM_COLS = 64,
  parameter int SYNC_STAGES = 2,
  localparam int ADDR_W = $clog2(NUM_ROWS / 2)
) (
  input  logic                  clk_in,
  input  logic                  n_reset_in,
  input  logic                  bit_clk_in,
  input  logic [2:0]            rgb_top_in,
  input  logic [2:0]            rgb_bot_in,
  input  logic [ADDR_W-1:0]     addr_in,
  input  logic                  latch_enable_in,
  input  logic                  output_enable_in,
  output logic                  row_valid_out,
  input  logic                  row_ready_in,
  output logic [ADDR_W-1:0]     row_addr_out,
  output logic [3*NUM_COLS-1:0] row_top_out,
  output logic [3*NUM_COLS-1:0] row_bot_out,
  output logic                  row_oe_out,
  output logic                  col_err_out,
  output logic                  overflow_out,
  output logic                  frame_done_out
);
  localparam int SW = 9 + ADDR_W;
  localparam int CW = $clog2(NUM_COLS + 2);
  localparam int RW = 3 * NUM_COLS;

  logic [SW-1:0] sync [SYNC_STAGES];
  logic [SW-1:0] hist, s;
  logic p_bit, p_lat, p_oe;
  logic [2:0] p_top, p_bot;
  logic [ADDR_W-1:0] p_addr;
  logic [RW-1:0] top_sr, bot_sr, top_n, bot_n;
  logic [CW-1:0] cnt, cnt_n;
  logic load;

  assign s = sync[SYNC_STAGES-1];

  // Pin synchronizers, edge history and a registered edge/data stage so shift and capture stay aligned
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
      hist <= '0;
      p_bit <= 1'b0;
      p_lat <= 1'b0;
      p_oe <= 1'b0;
      p_top <= '0;
      p_bot <= '0;
      p_addr <= '0;
    end else begin
      sync[0] <= {addr_in, rgb_bot_in, rgb_top_in, output_enable_in, latch_enable_in, bit_clk_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      hist <= s;
      p_bit <= s[0] & ~hist[0];
      p_lat <= s[1] & ~hist[1];
      p_oe <= s[2];
      p_top <= s[5:3];
      p_bot <= s[8:6];
      p_addr <= s[SW-1:9];
    end
  end

  // Shift-register next state includes a same-cycle bit so a simultaneous latch captures it
  always_comb begin
    top_n = p_bit ? {top_sr[RW-4:0], p_top} : top_sr;
    bot_n = p_bit ? {bot_sr[RW-4:0], p_bot} : bot_sr;
    cnt_n = (p_bit && cnt != CW'(NUM_COLS + 1)) ? cnt + CW'(1) : cnt;
    load = p_lat & (~row_valid_out | row_ready_in);
  end

  // Shift registers, column counter, one-entry record slot and status pulses
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      top_sr <= '0;
      bot_sr <= '0;
      cnt <= '0;
      row_valid_out <= 1'b0;
      row_addr_out <= '0;
      row_top_out <= '0;
      row_bot_out <= '0;
      row_oe_out <= 1'b0;
      col_err_out <= 1'b0;
      overflow_out <= 1'b0;
      frame_done_out <= 1'b0;
    end else begin
      top_sr <= top_n;
      bot_sr <= bot_n;
      cnt <= p_lat ? CW'(p_bit) : cnt_n;
      if (load) begin
        row_valid_out <= 1'b1;
        row_addr_out <= p_addr;
        row_top_out <= top_n;
        row_bot_out <= bot_n;
        row_oe_out <= p_oe;
      end else if (row_ready_in) begin
        row_valid_out <= 1'b0;
      end
      col_err_out <= p_lat & (cnt_n != CW'(NUM_COLS));
      overflow_out <= p_lat & ~load;
      frame_done_out <= load & (p_addr == ADDR_W'(NUM_ROWS / 2 - 1));
    end
  end
endmodule

// File: tb/tb_led_panel_receiver.sv
// tb_led_panel_receiver: directed vector table plus multi-cycle sequences for led_panel_receiver
module tb_led_panel_receiver;
  logic clk = 1'b0;
  logic n_reset = 1'b0;
  logic bit_clk = 1'b0;
  logic [2:0] rgb_top = '0;
  logic [2:0] rgb_bot = '0;
  logic [3:0] addr = '0;
  logic latch = 1'b0;
  logic oe = 1'b0;
  logic row_ready = 1'b0;
  logic row_valid, row_oe, col_err, overflow, frame_done;
  logic [3:0] row_addr;
  logic [191:0] row_top, row_bot;

  int n_vec = 0;
  int n_err = 0;
  int ovf_cnt = 0;
  int err_cnt = 0;
  int fd_cnt = 0;
  int fd_misalign = 0;
  int acc_n = 0;
  int acc_addr [32];

  led_panel_receiver dut (
    .clk_in(clk),
    .n_reset_in(n_reset),
    .bit_clk_in(bit_clk),
    .rgb_top_in(rgb_top),
    .rgb_bot_in(rgb_bot),
    .addr_in(addr),
    .latch_enable_in(latch),
    .output_enable_in(oe),
    .row_valid_out(row_valid),
    .row_ready_in(row_ready),
    .row_addr_out(row_addr),
    .row_top_out(row_top),
    .row_bot_out(row_bot),
    .row_oe_out(row_oe),
    .col_err_out(col_err),
    .overflow_out(overflow),
    .frame_done_out(frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (n_reset) begin
      if (overflow) ovf_cnt++;
      if (col_err) err_cnt++;
      if (frame_done) begin
        fd_cnt++;
        if (!(row_valid && row_addr == 4'd15)) fd_misalign++;
      end
      if (row_valid && row_ready && acc_n < 32) begin
        acc_addr[acc_n] = int'(row_addr);
        acc_n++;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic shift_bits(input int n, input int mark, input logic [2:0] mrgb,
                            input logic [2:0] btop, input logic [2:0] bbot);
    for (int i = 0; i < n; i++) begin
      rgb_top = (i == mark) ? mrgb : btop;
      rgb_bot = bbot;
      bit_clk = 1'b0;
      repeat (2) @(negedge clk);
      bit_clk = 1'b1;
      repeat (2) @(negedge clk);
    end
    bit_clk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic latch_row(input logic [3:0] a, input logic o, output int lat);
    addr = a;
    oe = o;
    @(negedge clk);
    latch = 1'b1;
    lat = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 2) latch = 1'b0;
      if (row_valid) begin
        lat = k;
        break;
      end
    end
    latch = 1'b0;
  endtask

  task automatic pulse_latch(input logic [3:0] a, input logic o);
    addr = a;
    oe = o;
    @(negedge clk);
    latch = 1'b1;
    repeat (2) @(negedge clk);
    latch = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  typedef struct {
    int nbits;
    int mark;
    logic [2:0] mrgb;
    logic [2:0] btop;
    logic [2:0] bbot;
    logic [3:0] addr;
    logic oe;
    logic [191:0] etop;
    logic [191:0] ebot;
    logic eerr;
  } vec_t;

  vec_t tv [4];
  int lat, e0, o0, f0, a0, bad;

  initial begin
    tv[0] = '{64, 0, 3'b001, 3'b000, 3'b000, 4'd5, 1'b1, 192'(3'b001) << 189, 192'd0, 1'b0};
    tv[1] = '{64, -1, 3'b000, 3'b101, 3'b101, 4'd3, 1'b0, {64{3'b101}}, {64{3'b101}}, 1'b0};
    tv[2] = '{63, -1, 3'b000, 3'b010, 3'b000, 4'd7, 1'b1, {3'b101, {63{3'b010}}}, {3'b101, {63{3'b000}}}, 1'b1};
    tv[3] = '{70, 6, 3'b100, 3'b000, 3'b011, 4'd9, 1'b0, 192'(3'b100) << 189, {64{3'b011}}, 1'b1};

    repeat (3) @(negedge clk);
    chk("reset_valid", 192'(row_valid), 192'd0);
    chk("reset_addr", 192'(row_addr), 192'd0);
    chk("reset_top", row_top, 192'd0);
    chk("reset_bot", row_bot, 192'd0);
    chk("reset_pulses", 192'({row_oe, col_err, overflow, frame_done}), 192'd0);
    n_reset = 1'b1;
    repeat (2) @(negedge clk);

    row_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      e0 = err_cnt;
      shift_bits(tv[v].nbits, tv[v].mark, tv[v].mrgb, tv[v].btop, tv[v].bbot);
      latch_row(tv[v].addr, tv[v].oe, lat);
      chk($sformatf("v%0d_latency", v), 192'(lat), 192'd4);
      chk($sformatf("v%0d_addr", v), 192'(row_addr), 192'(tv[v].addr));
      chk($sformatf("v%0d_top", v), row_top, tv[v].etop);
      chk($sformatf("v%0d_bot", v), row_bot, tv[v].ebot);
      chk($sformatf("v%0d_oe", v), 192'(row_oe), 192'(tv[v].oe));
      chk($sformatf("v%0d_col_err", v), 192'(col_err), 192'(tv[v].eerr));
      chk($sformatf("v%0d_frame_done", v), 192'(frame_done), 192'd0);
      @(negedge clk);
      chk($sformatf("v%0d_consumed", v), 192'(row_valid), 192'd0);
      chk($sformatf("v%0d_err_count", v), 192'(err_cnt - e0), 192'(tv[v].eerr));
    end

    row_ready = 1'b0;
    o0 = ovf_cnt;
    shift_bits(64, -1, 3'b000, 3'b001, 3'b000);
    pulse_latch(4'd1, 1'b1);
    shift_bits(64, -1, 3'b000, 3'b010, 3'b000);
    pulse_latch(4'd2, 1'b0);
    chk("ovf_valid", 192'(row_valid), 192'd1);
    chk("ovf_addr_held", 192'(row_addr), 192'd1);
    chk("ovf_top_held", row_top, {64{3'b001}});
    chk("ovf_oe_held", 192'(row_oe), 192'd1);
    chk("ovf_pulses", 192'(ovf_cnt - o0), 192'd1);
    row_ready = 1'b1;
    @(negedge clk);
    chk("ovf_accepted", 192'(row_valid), 192'd0);
    a0 = acc_n;
    repeat (10) @(negedge clk);
    chk("ovf_no_second_row", 192'({row_valid, 5'(acc_n - a0)}), 192'd0);

    acc_n = 0;
    f0 = fd_cnt;
    fd_misalign = 0;
    for (int a = 0; a < 16; a++) begin
      shift_bits(64, -1, 3'b000, 3'(a % 8), 3'b000);
      pulse_latch(4'(a), 1'b1);
    end
    chk("frame_count", 192'(acc_n), 192'd16);
    bad = 0;
    for (int i = 0; i < 16; i++) if (acc_addr[i] != i) bad++;
    chk("frame_order", 192'(bad), 192'd0);
    chk("frame_done_count", 192'(fd_cnt - f0), 192'd1);
    chk("frame_done_align", 192'(fd_misalign), 192'd0);

    row_ready = 1'b0;
    shift_bits(64, -1, 3'b000, 3'b111, 3'b000);
    pulse_latch(4'd4, 1'b1);
    chk("rst_pre_valid", 192'(row_valid), 192'd1);
    shift_bits(30, -1, 3'b000, 3'b011, 3'b011);
    n_reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", 192'(row_valid), 192'd0);
    chk("rst_addr", 192'(row_addr), 192'd0);
    chk("rst_top", row_top, 192'd0);
    chk("rst_bot", row_bot, 192'd0);
    chk("rst_flags", 192'({row_oe, col_err, overflow, frame_done}), 192'd0);
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    row_ready = 1'b1;
    e0 = err_cnt;
    shift_bits(64, -1, 3'b000, 3'b110, 3'b001);
    latch_row(4'd6, 1'b1, lat);
    chk("post_rst_latency", 192'(lat), 192'd4);
    chk("post_rst_addr", 192'(row_addr), 192'd6);
    chk("post_rst_top", row_top, {64{3'b110}});
    chk("post_rst_bot", row_bot, {64{3'b001}});
    @(negedge clk);
    chk("post_rst_no_col_err", 192'(err_cnt - e0), 192'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
